// File: rtl/ysyx_22051468_decode_queue_pkg.sv
// Shared decode constants: RISC-V opcodes, 4-bit class codes, EBREAK encoding
// and the packed control payload carried by every queue entry.
package ysyx_22051468_decode_queue_pkg;

  localparam logic [6:0]  OPC_LUI      = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
  localparam logic [6:0]  OPC_OP_IMM_W = 7'b0011011;
  localparam logic [6:0]  OPC_JALR     = 7'b1100111;
  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [6:0]  OPC_OP       = 7'b0110011;
  localparam logic [6:0]  OPC_OP_W     = 7'b0111011;
  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OPC_STORE    = 7'b0100011;
  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;

  typedef enum logic [3:0] {
    CLS_ILLEGAL  = 4'd0,
    CLS_LUI      = 4'd1,
    CLS_AUIPC    = 4'd2,
    CLS_OP_IMM   = 4'd3,
    CLS_LOAD     = 4'd4,
    CLS_OP_IMM_W = 4'd5,
    CLS_JALR     = 4'd6,
    CLS_JAL      = 4'd7,
    CLS_OP       = 4'd8,
    CLS_OP_W     = 4'd9,
    CLS_BRANCH   = 4'd10,
    CLS_STORE    = 4'd11,
    CLS_EBREAK   = 4'd12
  } inst_class_t;

  typedef struct packed {
    inst_class_t cls;
    logic        rd_need;
    logic        rs1_need;
    logic        rs2_need;
    logic        imm_need;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_w;
    logic        illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/ysyx_22051468_inst_field_decode.sv
// Purely combinational instruction decode: opcode class, sign-extended
// immediate, operand-need flags and control flags.
module ysyx_22051468_inst_field_decode
  import ysyx_22051468_decode_queue_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned INST_WIDTH = 32
) (
  input  logic [INST_WIDTH-1:0] inst,
  output logic [WIDTH-1:0]      imm,
  output dec_ctrl_t             ctrl
);

  logic [31:0]        ir;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  inst_class_t        cls;

  assign ir    = inst[31:0];
  assign imm_i = $signed({{20{ir[31]}}, ir[31:20]});
  assign imm_s = $signed({{20{ir[31]}}, ir[31:25], ir[11:7]});
  assign imm_b = $signed({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
  assign imm_u = $signed({ir[31:12], 12'b0});
  assign imm_j = $signed({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});

  // Every legal opcode ends in 2'b11, so compressed encodings fall to default.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (ir[6:0])
      OPC_LUI:      cls = CLS_LUI;
      OPC_AUIPC:    cls = CLS_AUIPC;
      OPC_OP_IMM:   cls = CLS_OP_IMM;
      OPC_LOAD:     cls = CLS_LOAD;
      OPC_OP_IMM_W: cls = CLS_OP_IMM_W;
      OPC_JALR:     cls = CLS_JALR;
      OPC_JAL:      cls = CLS_JAL;
      OPC_OP:       cls = CLS_OP;
      OPC_OP_W:     cls = CLS_OP_W;
      OPC_BRANCH:   cls = CLS_BRANCH;
      OPC_STORE:    cls = CLS_STORE;
      OPC_SYSTEM:   cls = (ir == INST_EBREAK) ? CLS_EBREAK : CLS_ILLEGAL;
      default:      cls = CLS_ILLEGAL;
    endcase
  end

  // Immediate select; sized casts of the signed 32-bit forms sign-extend to WIDTH.
  always_comb begin
    imm = '0;
    case (cls)
      CLS_LUI, CLS_AUIPC:                            imm = WIDTH'(imm_u);
      CLS_OP_IMM, CLS_LOAD, CLS_OP_IMM_W, CLS_JALR:  imm = WIDTH'(imm_i);
      CLS_STORE:                                     imm = WIDTH'(imm_s);
      CLS_BRANCH:                                    imm = WIDTH'(imm_b);
      CLS_JAL:                                       imm = WIDTH'(imm_j);
      default:                                       imm = '0;
    endcase
  end

  always_comb begin
    ctrl           = '0;
    ctrl.cls       = cls;
    ctrl.rd_need   = (cls inside {CLS_LUI, CLS_AUIPC, CLS_OP_IMM, CLS_LOAD, CLS_OP_IMM_W,
                                  CLS_JALR, CLS_JAL, CLS_OP, CLS_OP_W})
                     && (ir[11:7] != 5'd0);
    ctrl.rs1_need  = cls inside {CLS_OP_IMM, CLS_LOAD, CLS_OP_IMM_W, CLS_JALR,
                                 CLS_OP, CLS_OP_W, CLS_BRANCH, CLS_STORE};
    ctrl.rs2_need  = cls inside {CLS_OP, CLS_OP_W, CLS_BRANCH, CLS_STORE};
    ctrl.imm_need  = !(cls inside {CLS_OP, CLS_OP_W, CLS_EBREAK, CLS_ILLEGAL});
    ctrl.is_load   = (cls == CLS_LOAD);
    ctrl.is_store  = (cls == CLS_STORE);
    ctrl.is_branch = (cls == CLS_BRANCH);
    ctrl.is_jal    = (cls == CLS_JAL);
    ctrl.is_jalr   = (cls == CLS_JALR);
    ctrl.is_w      = (cls == CLS_OP_IMM_W) || (cls == CLS_OP_W);
    ctrl.illegal   = (cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/ysyx_22051468_decode_queue.sv
// Decode stage feeding a DEPTH-entry decoded-instruction FIFO towards issue.
// Define YSYX_22051468_DEQ_BYPASS_EN to forward into an empty queue in the same cycle.
module ysyx_22051468_decode_queue
  import ysyx_22051468_decode_queue_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INST_WIDTH-1:0]   in_inst,
  input  logic [WIDTH-1:0]        in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INST_WIDTH-1:0]   out_inst,
  output logic [WIDTH-1:0]        out_pc,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic [WIDTH-1:0]        out_imm,
  output logic [3:0]              out_class,
  output logic                    out_rd_need,
  output logic                    out_rs1_need,
  output logic                    out_rs2_need,
  output logic                    out_imm_need,
  output logic                    out_is_load,
  output logic                    out_is_store,
  output logic                    out_is_branch,
  output logic                    out_is_jal,
  output logic                    out_is_jalr,
  output logic                    out_is_w,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      imm;
    dec_ctrl_t             ctrl;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             in_entry;
  entry_t             sel;
  dec_ctrl_t          in_ctrl;
  logic [WIDTH-1:0]   in_imm;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               empty;
  logic               bypass;
  logic               push;
  logic               pop;

  ysyx_22051468_inst_field_decode #(
    .WIDTH      (WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_dec (
    .inst (in_inst),
    .imm  (in_imm),
    .ctrl (in_ctrl)
  );

  assign in_entry = '{inst: in_inst, pc: in_pc, imm: in_imm, ctrl: in_ctrl};
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !rst;

`ifdef YSYX_22051468_DEQ_BYPASS_EN
  assign bypass = empty && in_valid && out_ready && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction is consumed directly and never occupies storage.
  assign push = in_valid && in_ready && !flush && !bypass;
  assign pop  = !empty && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign sel       = bypass ? in_entry : mem[rd_ptr];
  assign out_valid = !empty || bypass;

  assign out_inst      = sel.inst;
  assign out_pc        = sel.pc;
  assign out_imm       = sel.imm;
  assign out_rs1       = sel.inst[19:15];
  assign out_rs2       = sel.inst[24:20];
  assign out_rd        = sel.inst[11:7];
  assign out_class     = sel.ctrl.cls;
  assign out_rd_need   = sel.ctrl.rd_need;
  assign out_rs1_need  = sel.ctrl.rs1_need;
  assign out_rs2_need  = sel.ctrl.rs2_need;
  assign out_imm_need  = sel.ctrl.imm_need;
  assign out_is_load   = sel.ctrl.is_load;
  assign out_is_store  = sel.ctrl.is_store;
  assign out_is_branch = sel.ctrl.is_branch;
  assign out_is_jal    = sel.ctrl.is_jal;
  assign out_is_jalr   = sel.ctrl.is_jalr;
  assign out_is_w      = sel.ctrl.is_w;
  assign out_illegal   = sel.ctrl.illegal;

endmodule
